// File: rtl/reservation_station_pkg.sv
// ---------------------------------------------------------------------------
// reservation_station_pkg
//
// Shared definitions for the ALU reservation station slice of the Tomasulo
// core: datapath widths, the micro-op opcode enumeration and the "empty"
// constants used for idle tags and cleared words.
// ---------------------------------------------------------------------------
package reservation_station_pkg;

    // Datapath widths shared with the dispatcher, ROB and ALU.
    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 32;
    localparam int ROB_TAG_WIDTH = 4;
    localparam int OP_WIDTH      = 6;

    // Micro-op opcodes handled by the ALU path. NOP (0) doubles as the
    // "nothing issued" marker on the issue port.
    typedef enum logic [OP_WIDTH-1:0] {
        OPENUM_NOP   = 6'd0,
        OPENUM_ADD   = 6'd1,
        OPENUM_SUB   = 6'd2,
        OPENUM_AND   = 6'd3,
        OPENUM_OR    = 6'd4,
        OPENUM_XOR   = 6'd5,
        OPENUM_SLL   = 6'd6,
        OPENUM_SRL   = 6'd7,
        OPENUM_SRA   = 6'd8,
        OPENUM_SLT   = 6'd9,
        OPENUM_SLTU  = 6'd10,
        OPENUM_LUI   = 6'd11,
        OPENUM_AUIPC = 6'd12,
        OPENUM_BEQ   = 6'd13,
        OPENUM_BNE   = 6'd14,
        OPENUM_BLT   = 6'd15,
        OPENUM_BGE   = 6'd16,
        OPENUM_BLTU  = 6'd17,
        OPENUM_BGEU  = 6'd18,
        OPENUM_JAL   = 6'd19,
        OPENUM_JALR  = 6'd20
    } openum_e;

    // Tag 0 means "no producer / value already present".
    localparam logic [ROB_TAG_WIDTH-1:0] ZERO_ROB  = '0;
    localparam logic [DATA_W-1:0]        ZERO_WORD = '0;

endpackage : reservation_station_pkg

// File: rtl/reservation_station_select.sv
// ---------------------------------------------------------------------------
// rs_select
//
// Lowest-index priority encoder. Used by the reservation station once over
// the free-slot vector (dispatch target) and once over the ready vector
// (issue candidate).
//
// Ports:
//   req   in  N      request vector, bit i set when slot i is a candidate
//   found out 1      at least one request bit is set
//   idx   out IDX_W  index of the lowest set request bit (0 when none)
// ---------------------------------------------------------------------------
module rs_select #(
    parameter  int N     = 16,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves a value unassigned and no
    // latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan from the top down so the last hit written is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule : rs_select

// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Out-of-order issue buffer between the dispatcher and the ALU. Holds up to
// RS_SIZE arithmetic/branch/jump micro-ops, wakes their operands by snooping
// the ALU and LSB result broadcasts, and issues the lowest-index ready entry
// each cycle into a registered operand bundle for the ALU.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rdy                 global enable; when low entries freeze and no issue
//   flush               misprediction rollback; discards every entry
//   in_valid, in_*      micro-op from the dispatcher (tags 0 = value present)
//   alu_rob_tag/value   ALU result broadcast (tag 0 = idle)
//   lsb_rob_tag/value   LSB result broadcast (tag 0 = idle)
//   out_full            no free entry; dispatcher back-pressure
//   out_op, out_*       registered issue bundle; out_op = NOP means no issue
// ---------------------------------------------------------------------------
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE   = 16,
    parameter int ROB_TAG_W = ROB_TAG_WIDTH,
    parameter int OP_W      = OP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,

    input  logic                 in_valid,
    input  logic [OP_W-1:0]      in_op,
    input  logic [DATA_W-1:0]    in_value1,
    input  logic [DATA_W-1:0]    in_value2,
    input  logic [ROB_TAG_W-1:0] in_tag1,
    input  logic [ROB_TAG_W-1:0] in_tag2,
    input  logic [DATA_W-1:0]    in_imm,
    input  logic [ADDR_W-1:0]    in_pc,
    input  logic [ROB_TAG_W-1:0] in_rob_tag,

    input  logic [ROB_TAG_W-1:0] alu_rob_tag,
    input  logic [DATA_W-1:0]    alu_value,
    input  logic [ROB_TAG_W-1:0] lsb_rob_tag,
    input  logic [DATA_W-1:0]    lsb_value,

    output logic                 out_full,
    output logic [OP_W-1:0]      out_op,
    output logic [DATA_W-1:0]    out_value1,
    output logic [DATA_W-1:0]    out_value2,
    output logic [DATA_W-1:0]    out_imm,
    output logic [ADDR_W-1:0]    out_pc,
    output logic [ROB_TAG_W-1:0] out_rob_tag
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    localparam logic [OP_W-1:0]      NOP_OP = OP_W'(OPENUM_NOP);
    localparam logic [ROB_TAG_W-1:0] NO_TAG = ROB_TAG_W'(ZERO_ROB);

    // One source operand: a value that is valid once its tag reads zero.
    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    val;
    } opnd_t;

    // Payload of one station entry. The busy bit lives in its own vector so
    // it can be reset and priority-encoded on its own.
    typedef struct packed {
        logic [OP_W-1:0]      op;
        opnd_t                src1;
        opnd_t                src2;
        logic [DATA_W-1:0]    imm;
        logic [ADDR_W-1:0]    pc;
        logic [ROB_TAG_W-1:0] rob_tag;
    } entry_t;

    // Capture a broadcast result if it carries the tag this operand is
    // waiting on. The ALU is checked first so it wins if both buses ever
    // carry the same tag.
    function automatic opnd_t snoop(
        input opnd_t                o,
        input logic [ROB_TAG_W-1:0] a_tag,
        input logic [DATA_W-1:0]    a_val,
        input logic [ROB_TAG_W-1:0] l_tag,
        input logic [DATA_W-1:0]    l_val
    );
        opnd_t r;
        r = o;
        if (a_tag != NO_TAG && o.tag == a_tag) begin
            r.tag = NO_TAG;
            r.val = a_val;
        end else if (l_tag != NO_TAG && o.tag == l_tag) begin
            r.tag = NO_TAG;
            r.val = l_val;
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [RS_SIZE-1:0]   busy_q, busy_d;
    entry_t               ent_q [RS_SIZE];
    entry_t               ent_d [RS_SIZE];

    logic [OP_W-1:0]      out_op_q,      out_op_d;
    logic [DATA_W-1:0]    out_value1_q,  out_value1_d;
    logic [DATA_W-1:0]    out_value2_q,  out_value2_d;
    logic [DATA_W-1:0]    out_imm_q,     out_imm_d;
    logic [ADDR_W-1:0]    out_pc_q,      out_pc_d;
    logic [ROB_TAG_W-1:0] out_rob_tag_q, out_rob_tag_d;

    // ---------------------------------------------------------------------
    // Slot selection (both decoded from registered state only, so an entry
    // written or woken at an edge is first eligible in the following cycle)
    // ---------------------------------------------------------------------
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_found;
    logic [IDX_W-1:0]   issue_idx;

    always_comb begin
        free_vec  = ~busy_q;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy_q[i]
                        && ent_q[i].src1.tag == NO_TAG
                        && ent_q[i].src2.tag == NO_TAG;
        end
    end

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.N(RS_SIZE)) u_issue_sel (
        .req   (ready_vec),
        .found (issue_found),
        .idx   (issue_idx)
    );

    assign out_full = &busy_q;

    // ---------------------------------------------------------------------
    // Next-state logic. Priority: flush, then stall, then the normal
    // wakeup / issue / dispatch cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        busy_d        = busy_q;
        ent_d         = ent_q;
        out_op_d      = out_op_q;
        out_value1_d  = out_value1_q;
        out_value2_d  = out_value2_q;
        out_imm_d     = out_imm_q;
        out_pc_d      = out_pc_q;
        out_rob_tag_d = out_rob_tag_q;

        if (flush) begin
            busy_d        = '0;
            out_op_d      = NOP_OP;
            out_rob_tag_d = NO_TAG;
        end else if (!rdy) begin
            // Entries hold; the issue port drops to NOP so the ALU does not
            // re-execute and re-broadcast the last issued micro-op.
            out_op_d      = NOP_OP;
            out_rob_tag_d = NO_TAG;
        end else begin
            // Wakeup of entries already waiting in the station.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    ent_d[i].src1 = snoop(ent_q[i].src1, alu_rob_tag, alu_value,
                                          lsb_rob_tag, lsb_value);
                    ent_d[i].src2 = snoop(ent_q[i].src2, alu_rob_tag, alu_value,
                                          lsb_rob_tag, lsb_value);
                end
            end

            // Issue. A ready entry has both tags clear, so its registered
            // operand values are final and wakeup cannot touch them.
            if (issue_found) begin
                out_op_d           = ent_q[issue_idx].op;
                out_value1_d       = ent_q[issue_idx].src1.val;
                out_value2_d       = ent_q[issue_idx].src2.val;
                out_imm_d          = ent_q[issue_idx].imm;
                out_pc_d           = ent_q[issue_idx].pc;
                out_rob_tag_d      = ent_q[issue_idx].rob_tag;
                busy_d[issue_idx]  = 1'b0;
            end else begin
                out_op_d      = NOP_OP;
                out_rob_tag_d = NO_TAG;
            end

            // Dispatch into the lowest free slot. The free slot comes from
            // the registered busy vector, so a slot vacated by this cycle's
            // issue is not reused until next cycle and a full station rejects
            // the micro-op even while it issues. Operands also snoop this
            // cycle's broadcasts so a result on the bus now is not missed.
            if (in_valid && free_found) begin
                ent_d[free_idx].op      = in_op;
                ent_d[free_idx].src1    = snoop('{tag: in_tag1, val: in_value1},
                                                alu_rob_tag, alu_value,
                                                lsb_rob_tag, lsb_value);
                ent_d[free_idx].src2    = snoop('{tag: in_tag2, val: in_value2},
                                                alu_rob_tag, alu_value,
                                                lsb_rob_tag, lsb_value);
                ent_d[free_idx].imm     = in_imm;
                ent_d[free_idx].pc      = in_pc;
                ent_d[free_idx].rob_tag = in_rob_tag;
                busy_d[free_idx]        = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q        <= '0;
            out_op_q      <= NOP_OP;
            out_value1_q  <= ZERO_WORD;
            out_value2_q  <= ZERO_WORD;
            out_imm_q     <= ZERO_WORD;
            out_pc_q      <= ADDR_W'(ZERO_WORD);
            out_rob_tag_q <= NO_TAG;
        end else begin
            busy_q        <= busy_d;
            out_op_q      <= out_op_d;
            out_value1_q  <= out_value1_d;
            out_value2_q  <= out_value2_d;
            out_imm_q     <= out_imm_d;
            out_pc_q      <= out_pc_d;
            out_rob_tag_q <= out_rob_tag_d;
        end
    end

    // NOTE: the entry payload array is deliberately not reset. Its contents
    // are only ever observed through a set busy bit, and busy is reset, so
    // clearing the storage would add reset fan-out for no behavioural gain.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign out_op      = out_op_q;
    assign out_value1  = out_value1_q;
    assign out_value2  = out_value2_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign out_rob_tag = out_rob_tag_q;

endmodule : reservation_station

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//
// Directed bench for reservation_station. A table of per-cycle records
// (inputs applied in a cycle plus the issue bundle expected in that cycle)
// covers dispatch, wakeup, dispatch-cycle bypass, back-to-back dependence and
// ordered issue; hand-written sequences cover full, flush, rdy stall and
// asynchronous reset. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_value1, in_value2, in_imm, in_pc;
    logic [3:0]  in_tag1, in_tag2, in_rob_tag;
    logic [3:0]  alu_rob_tag, lsb_rob_tag;
    logic [31:0] alu_value, lsb_value;
    logic        out_full;
    logic [5:0]  out_op;
    logic [31:0] out_value1, out_value2, out_imm, out_pc;
    logic [3:0]  out_rob_tag;

    int n_vec  = 0;
    int n_miss = 0;
    int n_viol = 0;

    localparam logic [5:0] NOP = OPENUM_NOP;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_op       (in_op),
        .in_value1   (in_value1),
        .in_value2   (in_value2),
        .in_tag1     (in_tag1),
        .in_tag2     (in_tag2),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .in_rob_tag  (in_rob_tag),
        .alu_rob_tag (alu_rob_tag),
        .alu_value   (alu_value),
        .lsb_rob_tag (lsb_rob_tag),
        .lsb_value   (lsb_value),
        .out_full    (out_full),
        .out_op      (out_op),
        .out_value1  (out_value1),
        .out_value2  (out_value2),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_rob_tag (out_rob_tag)
    );

    // Dispatcher protocol monitor: in_valid while the station is full.
    always @(posedge clk) begin
        if (rst && in_valid && out_full) begin
            n_viol++;
            $display("protocol violation flagged at %0t: in_valid while out_full", $time);
        end
    end

    // Watchdog: the bench uses fixed cycle counts, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Immediate/pc are tied to the destination tag so the issued bundle can
    // be checked against the micro-op that produced it.
    function automatic logic [31:0] imm_of(input logic [3:0] rob);
        return 32'h0000_1000 + 32'(rob);
    endfunction
    function automatic logic [31:0] pc_of(input logic [3:0] rob);
        return 32'h8000_0000 + 32'(rob) * 4;
    endfunction

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [3:0]  t1, t2;
        logic [31:0] v1, v2;
        logic [3:0]  rob;
        logic [3:0]  at;
        logic [31:0] av;
        logic [3:0]  lt;
        logic [31:0] lv;
        logic [5:0]  e_op;
        logic [31:0] e_v1, e_v2;
        logic [3:0]  e_rob;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [5:0] op, input logic [3:0] t1, input logic [3:0] t2,
        input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] rob,
        input logic [3:0] at, input logic [31:0] av, input logic [3:0] lt, input logic [31:0] lv,
        input logic [5:0] e_op, input logic [31:0] e_v1, input logic [31:0] e_v2, input logic [3:0] e_rob);
        vec_t r;
        r.v = v; r.op = op; r.t1 = t1; r.t2 = t2; r.v1 = v1; r.v2 = v2; r.rob = rob;
        r.at = at; r.av = av; r.lt = lt; r.lv = lv;
        r.e_op = e_op; r.e_v1 = e_v1; r.e_v2 = e_v2; r.e_rob = e_rob;
        return r;
    endfunction

    function automatic vec_t idl(input logic [5:0] e_op, input logic [31:0] e_v1,
                                 input logic [31:0] e_v2, input logic [3:0] e_rob);
        return mk(1'b0, NOP, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0,
                  4'd0, 32'd0, 4'd0, 32'd0, e_op, e_v1, e_v2, e_rob);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [3:0] t1,
                         input logic [3:0] t2, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [3:0] rob);
        in_valid   = v;
        in_op      = op;
        in_tag1    = t1;
        in_tag2    = t2;
        in_value1  = v1;
        in_value2  = v2;
        in_rob_tag = rob;
        in_imm     = imm_of(rob);
        in_pc      = pc_of(rob);
    endtask

    task automatic bcast(input logic [3:0] at, input logic [31:0] av,
                         input logic [3:0] lt, input logic [31:0] lv);
        alu_rob_tag = at;
        alu_value   = av;
        lsb_rob_tag = lt;
        lsb_value   = lv;
    endtask

    task automatic idle();
        drive(1'b0, NOP, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0);
        bcast(4'd0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    // Compare the issue bundle; operand fields are only meaningful on issue.
    task automatic check_out(input string name, input logic [5:0] e_op, input logic [31:0] e_v1,
                             input logic [31:0] e_v2, input logic [3:0] e_rob, input logic e_full);
        check({name, ".op"},   32'(out_op), 32'(e_op));
        check({name, ".rob"},  32'(out_rob_tag), 32'(e_rob));
        check({name, ".full"}, 32'(out_full), 32'(e_full));
        if (e_op != NOP) begin
            check({name, ".v1"},  out_value1, e_v1);
            check({name, ".v2"},  out_value2, e_v2);
            check({name, ".imm"}, out_imm, imm_of(e_rob));
            check({name, ".pc"},  out_pc, pc_of(e_rob));
        end
    endtask

    vec_t vecs [24];

    initial begin
        // Ready dispatch: ADD 5/7 -> rob 3, visible two cycles later.
        vecs[0]  = mk(1, OPENUM_ADD, 4'd0, 4'd0, 5, 7, 4'd3, 4'd0, 0, 4'd0, 0, NOP, 0, 0, 4'd0);
        vecs[1]  = idl(NOP, 0, 0, 4'd0);
        vecs[2]  = idl(OPENUM_ADD, 5, 7, 4'd3);
        vecs[3]  = idl(NOP, 0, 0, 4'd0);
        // Wakeup from LSB in cycle 6, issue in cycle 8.
        vecs[4]  = mk(1, OPENUM_SUB, 4'd4, 4'd0, 0, 1, 4'd5, 4'd0, 0, 4'd0, 0, NOP, 0, 0, 4'd0);
        vecs[5]  = idl(NOP, 0, 0, 4'd0);
        vecs[6]  = mk(0, NOP, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 4'd4, 10, NOP, 0, 0, 4'd0);
        vecs[7]  = idl(NOP, 0, 0, 4'd0);
        vecs[8]  = idl(OPENUM_SUB, 10, 1, 4'd5);
        // Bypass: both operands satisfied by broadcasts in the dispatch cycle.
        vecs[9]  = mk(1, OPENUM_XOR, 4'd6, 4'd7, 0, 0, 4'd6, 4'd6, 32'h11, 4'd7, 32'h22, NOP, 0, 0, 4'd0);
        vecs[10] = idl(NOP, 0, 0, 4'd0);
        vecs[11] = idl(OPENUM_XOR, 32'h11, 32'h22, 4'd6);
        // Back-to-back: producer on out in cycle 14, dependent on out in 16.
        vecs[12] = mk(1, OPENUM_ADD, 4'd0, 4'd0, 1, 2, 4'd1, 4'd0, 0, 4'd0, 0, NOP, 0, 0, 4'd0);
        vecs[13] = mk(1, OPENUM_OR, 4'd1, 4'd2, 0, 0, 4'd2, 4'd0, 0, 4'd0, 0, NOP, 0, 0, 4'd0);
        vecs[14] = mk(0, NOP, 4'd0, 4'd0, 0, 0, 4'd0, 4'd1, 3, 4'd2, 32'h40, OPENUM_ADD, 1, 2, 4'd1);
        vecs[15] = idl(NOP, 0, 0, 4'd0);
        vecs[16] = idl(OPENUM_OR, 3, 32'h40, 4'd2);
        // Two entries woken together issue in index order; ALU beats LSB.
        vecs[17] = mk(1, OPENUM_AND, 4'd8, 4'd0, 0, 32'hF, 4'd9, 4'd0, 0, 4'd0, 0, NOP, 0, 0, 4'd0);
        vecs[18] = mk(1, OPENUM_SLL, 4'd8, 4'd0, 0, 3, 4'd10, 4'd0, 0, 4'd0, 0, NOP, 0, 0, 4'd0);
        vecs[19] = mk(0, NOP, 4'd0, 4'd0, 0, 0, 4'd0, 4'd8, 32'h80, 4'd8, 32'h99, NOP, 0, 0, 4'd0);
        vecs[20] = idl(NOP, 0, 0, 4'd0);
        vecs[21] = idl(OPENUM_AND, 32'h80, 32'hF, 4'd9);
        vecs[22] = idl(OPENUM_SLL, 32'h80, 3, 4'd10);
        vecs[23] = idl(NOP, 0, 0, 4'd0);

        // ---------------- reset state ----------------
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset.op",   32'(out_op), 32'(NOP));
        check("reset.rob",  32'(out_rob_tag), 32'd0);
        check("reset.v1",   out_value1, 32'd0);
        check("reset.v2",   out_value2, 32'd0);
        check("reset.imm",  out_imm, 32'd0);
        check("reset.pc",   out_pc, 32'd0);
        check("reset.full", 32'(out_full), 32'd0);
        rst = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].t1, vecs[i].t2, vecs[i].v1, vecs[i].v2, vecs[i].rob);
            bcast(vecs[i].at, vecs[i].av, vecs[i].lt, vecs[i].lv);
            check_out($sformatf("vec%0d", i), vecs[i].e_op, vecs[i].e_v1, vecs[i].e_v2, vecs[i].e_rob, 1'b0);
            tick();
        end
        idle();

        // ---------------- full: 16 waiting entries, 17th dropped ----------------
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, OPENUM_ADD, 4'd9, 4'd0, 32'd0, 32'(i), 4'((i % 15) + 1));
            check_out($sformatf("fill%0d", i), NOP, 0, 0, 4'd0, 1'b0);
            tick();
        end
        drive(1'b1, OPENUM_SUB, 4'd0, 4'd0, 32'hDEAD, 32'hBEEF, 4'd15);
        check_out("full.reject1", NOP, 0, 0, 4'd0, 1'b1);
        tick();
        idle();
        bcast(4'd9, 32'h900, 4'd0, 32'd0);
        check_out("full.wake", NOP, 0, 0, 4'd0, 1'b1);
        tick();
        // Entry 0 is being selected this cycle while still full: reject again.
        idle();
        drive(1'b1, OPENUM_SUB, 4'd0, 4'd0, 32'hDEAD, 32'hBEEF, 4'd15);
        check_out("full.reject2", NOP, 0, 0, 4'd0, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            check_out($sformatf("drain%0d", i), OPENUM_ADD, 32'h900, 32'(i), 4'((i % 15) + 1), 1'b0);
            tick();
        end
        check_out("drain.end0", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        check_out("drain.end1", NOP, 0, 0, 4'd0, 1'b0);
        check("protocol_violations", 32'(n_viol), 32'd2);

        // ---------------- flush ----------------
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i < 3) ? OPENUM_ADD : OPENUM_SUB, (i < 3) ? 4'd11 : 4'd12, 4'd0,
                  32'd0, 32'(i), 4'(i + 1));
            check_out($sformatf("flush.fill%0d", i), NOP, 0, 0, 4'd0, 1'b0);
            tick();
        end
        idle();
        bcast(4'd0, 32'd0, 4'd12, 32'h55);
        check_out("flush.wake", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        idle();
        flush = 1'b1;
        drive(1'b1, OPENUM_XOR, 4'd0, 4'd0, 32'd1, 32'd1, 4'd13);
        check_out("flush.cycle", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        check_out("flush.after", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        bcast(4'd11, 32'd1, 4'd12, 32'd2);
        check_out("flush.rewake", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("flush.quiet%0d", i), NOP, 0, 0, 4'd0, 1'b0);
            tick();
        end

        // ---------------- rdy stall ----------------
        drive(1'b1, OPENUM_ADD, 4'd0, 4'd0, 32'h77, 32'h88, 4'd7);
        check_out("stall.disp", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        idle();
        rdy = 1'b0;
        check_out("stall.c1", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        drive(1'b1, OPENUM_OR, 4'd0, 4'd0, 32'd1, 32'd1, 4'd8);
        check_out("stall.c2", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        idle();
        check_out("stall.c3", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        rdy = 1'b1;
        check_out("stall.resume", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        check_out("stall.issue", OPENUM_ADD, 32'h77, 32'h88, 4'd7, 1'b0);
        tick();
        check_out("stall.after0", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        check_out("stall.after1", NOP, 0, 0, 4'd0, 1'b0);
        tick();

        // ---------------- asynchronous reset mid-stream ----------------
        drive(1'b1, OPENUM_SUB, 4'd13, 4'd0, 32'd0, 32'd0, 4'd1);
        tick();
        drive(1'b1, OPENUM_SUB, 4'd13, 4'd0, 32'd0, 32'd0, 4'd2);
        tick();
        drive(1'b1, OPENUM_ADD, 4'd0, 4'd0, 32'hAA, 32'hBB, 4'd5);
        tick();
        drive(1'b1, OPENUM_SUB, 4'd13, 4'd0, 32'd0, 32'd0, 4'd3);
        tick();
        idle();
        check_out("rst.pre", OPENUM_ADD, 32'hAA, 32'hBB, 4'd5, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rst.async.op",   32'(out_op), 32'(NOP));
        check("rst.async.rob",  32'(out_rob_tag), 32'd0);
        check("rst.async.v1",   out_value1, 32'd0);
        check("rst.async.v2",   out_value2, 32'd0);
        check("rst.async.imm",  out_imm, 32'd0);
        check("rst.async.pc",   out_pc, 32'd0);
        check("rst.async.full", 32'(out_full), 32'd0);
        tick();
        rst = 1'b1;
        bcast(4'd13, 32'd7, 4'd0, 32'd0);
        check_out("rst.release", NOP, 0, 0, 4'd0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("rst.quiet%0d", i), NOP, 0, 0, 4'd0, 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_reservation_station
